// File: rtl/ifft_pkg.sv
// Shared constants, FSM state types and the base-4 digit reversal
// used by the IFFT64 output reorder path.
package ifft_pkg;

    localparam int LOG4N = 3;
    localparam int N     = 4 ** LOG4N;
    localparam int AW    = 2 * LOG4N;

    typedef enum logic {W_IDLE, W_FILL} wstate_t;
    typedef enum logic {R_IDLE, R_READ} rstate_t;

    // Reverse the order of the low 'digits' base-4 digits of a.
    function automatic logic [31:0] digit_rev(
        input logic [31:0] a,
        input int          digits
    );
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < digits) begin
                r[2*i +: 2] = a[2*(digits-1-i) +: 2];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port,
// both on clk. Bank selection is carried in the address MSB.
module sdp_ram #(
    parameter int DW = 32,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/digit_rev_reorder.sv
// Ping-pong reorder buffer: writes digit-reversed frames, reads them
// back in natural order while the next frame is being written.
module digit_rev_reorder
    import ifft_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int LOG4N  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] in_re,
    input  logic [DWIDTH-1:0] in_im,
    input  logic              in_valid,
    input  logic              in_start,
    output logic [DWIDTH-1:0] out_re,
    output logic [DWIDTH-1:0] out_im,
    output logic              out_valid,
    output logic              out_start
);

    localparam int NN  = 4 ** LOG4N;
    localparam int AWL = 2 * LOG4N;
    localparam logic [AWL-1:0] LAST = AWL'(NN - 1);

    wstate_t        ws, ws_n;
    rstate_t        rs, rs_n;
    logic [AWL-1:0] wr_cnt, wr_cnt_n;
    logic [AWL-1:0] rd_cnt, rd_cnt_n;
    logic [AWL-1:0] wr_addr, rd_addr;
    logic           wr_bank, rd_bank;
    logic [1:0]     full, full_n, avail;
    logic           wr_en, wr_done;
    logic           rd_issue, rd_last;
    logic           v1, s1;
    logic [2*DWIDTH-1:0] rdata;

    always_comb begin
        ws_n     = ws;
        wr_cnt_n = wr_cnt;
        wr_addr  = wr_cnt;
        wr_en    = 1'b0;
        wr_done  = 1'b0;
        if (in_valid) begin
            if (in_start) begin
                wr_en    = 1'b1;
                wr_addr  = '0;
                wr_cnt_n = AWL'(1);
                ws_n     = W_FILL;
            end else if (ws == W_FILL) begin
                wr_en = 1'b1;
                if (wr_cnt == LAST) begin
                    wr_done  = 1'b1;
                    wr_cnt_n = '0;
                    ws_n     = W_IDLE;
                end else begin
                    wr_cnt_n = wr_cnt + AWL'(1);
                end
            end
        end
    end

    // A bank completing this cycle may be read at once: address 0
    // of that frame was written long before the last sample.
    always_comb begin
        avail[0] = full[0] | (wr_done & ~wr_bank);
        avail[1] = full[1] | (wr_done & wr_bank);
        rd_issue = (rs == R_READ) | avail[rd_bank];
        rd_last  = rd_issue & (rd_cnt == LAST);
        rs_n     = rs;
        rd_cnt_n = rd_cnt;
        if (rd_issue) begin
            if (rd_last) begin
                rd_cnt_n = '0;
                rs_n = avail[~rd_bank] ? R_READ : R_IDLE;
            end else begin
                rd_cnt_n = rd_cnt + AWL'(1);
                rs_n     = R_READ;
            end
        end
        full_n = full;
        if (rd_last) begin
            full_n[rd_bank] = 1'b0;
        end
        if (wr_done) begin
            full_n[wr_bank] = 1'b1;
        end
        rd_addr = AWL'(digit_rev(32'(rd_cnt), LOG4N));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ws        <= W_IDLE;
            rs        <= R_IDLE;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            full      <= '0;
            v1        <= 1'b0;
            s1        <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
        end else begin
            ws        <= ws_n;
            rs        <= rs_n;
            wr_cnt    <= wr_cnt_n;
            rd_cnt    <= rd_cnt_n;
            full      <= full_n;
            wr_bank   <= wr_bank ^ wr_done;
            rd_bank   <= rd_bank ^ rd_last;
            v1        <= rd_issue;
            s1        <= rd_issue & (rd_cnt == '0);
            out_valid <= v1;
            out_start <= v1 & s1;
            if (v1) begin
                out_re <= rdata[2*DWIDTH-1:DWIDTH];
                out_im <= rdata[DWIDTH-1:0];
            end
        end
    end

    sdp_ram #(
        .DW(2 * DWIDTH),
        .AW(AWL + 1)
    ) u_ram (
        .clk  (clk),
        .we   (wr_en),
        .waddr({wr_bank, wr_addr}),
        .wdata({in_re, in_im}),
        .raddr({rd_bank, rd_addr}),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_digit_rev_reorder.sv
// Directed/random bench for digit_rev_reorder with a queue-based
// natural-order reference model.
module tb_digit_rev_reorder;

    localparam int DW = 16;
    localparam int NF = 64;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          st;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic          in_valid = 1'b0;
    logic          in_start = 1'b0;
    logic [DW-1:0] out_re, out_im;
    logic          out_valid, out_start;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int burst_len = 0;
    int last_burst = 0;
    logic prev_v = 1'b0;
    logic mon_en = 1'b1;

    exp_t exp_q[$];
    int   lat_q[$];
    logic [DW-1:0] fr_re [NF];
    logic [DW-1:0] fr_im [NF];

    digit_rev_reorder #(.DWIDTH(DW), .LOG4N(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_re    (in_re),
        .in_im    (in_im),
        .in_valid (in_valid),
        .in_start (in_start),
        .out_re   (out_re),
        .out_im   (out_im),
        .out_valid(out_valid),
        .out_start(out_start)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Natural index k holds the sample that arrived at position
    // with its three base-4 digits swapped end for end.
    function automatic int rev64(input int k);
        int d0, d1, d2;
        d0 = k % 4;
        d1 = (k / 4) % 4;
        d2 = k / 16;
        return d0 * 16 + d1 * 4 + d2;
    endfunction

    task automatic push_frame();
        exp_t e;
        for (int k = 0; k < NF; k++) begin
            e.re = fr_re[rev64(k)];
            e.im = fr_im[rev64(k)];
            e.st = (k == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input int n, input bit gap, input bit model);
        for (int p = 0; p < n; p++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_start = (p == 0);
            in_re    = fr_re[p];
            in_im    = fr_im[p];
            if (p == n - 1 && model) begin
                lat_q.push_back(cyc);
                push_frame();
            end
            if (gap && p != n - 1) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_start = 1'b0;
                in_re    = DW'($urandom);
                in_im    = DW'($urandom);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_start = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !out_valid && !prev_v) break;
            @(negedge clk);
            in_valid = 1'b0;
            in_start = 1'b0;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic ramp_frame(input int off);
        for (int p = 0; p < NF; p++) begin
            fr_re[p] = DW'(p + off);
            fr_im[p] = DW'(-(p + off));
        end
    endtask

    task automatic rand_frame();
        for (int p = 0; p < NF; p++) begin
            fr_re[p] = DW'($urandom);
            fr_im[p] = DW'($urandom);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            burst_len  = prev_v ? burst_len + 1 : 1;
            last_burst = burst_len;
        end
        prev_v = out_valid;
        if (mon_en && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_re", out_re, e.re);
                chk("out_im", out_im, e.im);
                chk("out_start", out_start, e.st);
                if (out_start && lat_q.size() > 0)
                    chk("start_latency", cyc - lat_q.pop_front(), 2);
            end
        end
    end

    initial begin
        int cnt0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_start", out_start, 0);
        chk("rst_re", out_re, 0);
        chk("rst_im", out_im, 0);
        rst = 1'b0;
        idle(2);

        // 1: ramp frame, gapless
        ramp_frame(0);
        send(NF, 1'b0, 1'b1);
        drain("t1_drain");
        chk("t1_burst", last_burst, NF);

        // 2: three back-to-back frames
        for (int f = 0; f < 3; f++) begin
            ramp_frame(100 * f);
            for (int p = 0; p < NF; p++) fr_im[p] = DW'($urandom);
            send(NF, 1'b0, 1'b1);
        end
        drain("t2_drain");
        chk("t2_burst", last_burst, 3 * NF);

        // 3: input with a gap every other cycle
        ramp_frame(0);
        send(NF, 1'b1, 1'b1);
        drain("t3_drain");
        chk("t3_burst", last_burst, NF);

        // 4: aborted partial frame, then a full random frame
        rand_frame();
        send(20, 1'b0, 1'b0);
        rand_frame();
        send(NF, 1'b0, 1'b1);
        drain("t4_drain");
        chk("t4_burst", last_burst, NF);

        // 5: valid without start is dropped
        cnt0 = checks;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 1) == 1);
            in_start = 1'b0;
            in_re    = DW'($urandom);
        end
        idle(10);
        chk("t5_no_output", checks - cnt0, 0);
        chk("t5_valid", out_valid, 0);

        // 6: reset at output sample 10, then a clean frame
        ramp_frame(0);
        send(NF, 1'b0, 1'b1);
        repeat (12) @(negedge clk);
        in_valid = 1'b0;
        in_start = 1'b0;
        mon_en = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        chk("t6_valid", out_valid, 0);
        chk("t6_re", out_re, 0);
        chk("t6_im", out_im, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_valid2", out_valid, 0);
        mon_en = 1'b1;
        idle(3);
        ramp_frame(0);
        send(NF, 1'b0, 1'b1);
        drain("t6_drain");
        chk("t6_burst", last_burst, NF);
        chk("lat_q_empty", lat_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
